// File: rtl/read_file_pkg.sv
// Shared types and helpers for the raw-image stream source.
package read_file_pkg;

  localparam int MAX_BPW        = 4;
  localparam int MAX_FILE_BYTES = 64;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/read_file_word.sv
// Byte-image word fetcher: the "file" is a parameter byte image read little-endian,
// with a byte cursor that can be rewound; bytes past the end read as 0x00.
module read_file_word
  import read_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FILE_LEN = 0,
  parameter logic [8*MAX_FILE_BYTES-1:0] FILE_BYTES = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rewind,
  input  logic                  fetch,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  eof,
  output logic                  open_fail
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int PTR_W = $clog2(MAX_FILE_BYTES + MAX_BPW + 1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] base;

  // An empty image stands in for a file that could not be opened.
  assign open_fail = (FILE_LEN == 0);
  assign base      = rewind ? '0 : ptr;
  assign eof       = (int'(base) + BPW) > FILE_LEN;

  always_comb begin
    word = '0;
    for (int i = 0; i < BPW; i++) begin
      if (int'(base) + i < FILE_LEN)
        word[8*i +: 8] = FILE_BYTES[8*(int'(base) + i) +: 8];
    end
  end

  // Cursor saturates at the image end so it never wraps during long padded frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (fetch)
      ptr <= eof ? PTR_W'(FILE_LEN) : base + PTR_W'(BPW);
    else if (rewind)
      ptr <= '0;
  end

endmodule

// File: rtl/read_file_stream.sv
// Streams a raw byte image as valid/ready pixel words with line (m_last) and
// frame (m_user) markers, optional inter-line gap, and a fixed frame count.
//
// state | meaning
// IDLE  | waiting for start_en; nothing presented
// SEND  | word presented, waiting for the handshake
// GAP   | idle cycles after a line's last word
// DONE  | all frames sent; terminal until reset
module read_file_stream
  import read_file_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int H_GAP      = 16,
  parameter int FRAME_NUM  = 1,
  parameter int FILE_LEN   = 0,
  parameter logic [8*MAX_FILE_BYTES-1:0] FILE_BYTES = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_en,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_user,
  output logic                  done,
  output logic                  eof_err
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FRM_W = (FRAME_NUM  > 1) ? $clog2(FRAME_NUM)  : 1;
  localparam int GAP_W = (H_GAP      > 1) ? $clog2(H_GAP)      : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_NUM - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam bit HAS_GAP = (H_GAP > 0);

  state_t state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [FRM_W-1:0] frame_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [DATA_WIDTH-1:0] word;
  logic eof, open_fail, fetch, rewind;
  logic start_go, xfer, at_col_last, line_end, frame_end, final_word;

  assign start_go    = (state == IDLE) && start_en && !open_fail;
  assign xfer        = (state == SEND) && m_ready;
  assign at_col_last = (col == COL_LAST);
  assign line_end    = xfer && at_col_last;
  assign frame_end   = line_end && (row == ROW_LAST);
  assign final_word  = frame_end && (frame_cnt == FRM_LAST);
  assign fetch       = start_go || (xfer && !final_word);
  assign rewind      = start_go || (frame_end && !final_word);

  read_file_word #(
    .DATA_WIDTH (DATA_WIDTH),
    .FILE_LEN   (FILE_LEN),
    .FILE_BYTES (FILE_BYTES)
  ) u_word (
    .clk       (clk),
    .rst_n     (rst_n),
    .rewind    (rewind),
    .fetch     (fetch),
    .word      (word),
    .eof       (eof),
    .open_fail (open_fail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_go) state_nxt = SEND;
      SEND: begin
        if (final_word)               state_nxt = DONE;
        else if (line_end && HAS_GAP) state_nxt = GAP;
      end
      GAP:  if (gap_cnt == '0) state_nxt = SEND;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Markers follow the position of the presented word and are quiet when not valid.
  always_comb begin
    m_valid = (state == SEND);
    m_last  = m_valid && at_col_last;
    m_user  = m_valid && (col == '0) && (row == '0);
    done    = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      m_data    <= '0;
      eof_err   <= 1'b0;
    end else begin
      if (open_fail || (fetch && eof)) eof_err <= 1'b1;
      if (fetch) m_data <= word;
      if (xfer) begin
        col <= at_col_last ? '0 : col + 1'b1;
        if (at_col_last) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        if (frame_end && !final_word) frame_cnt <= frame_cnt + 1'b1;
      end
      if (line_end)
        gap_cnt <= GAP_LOAD;
      else if ((state == GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
